// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning architectural HI/LO: pipelined multiplier,
// radix-2 restoring divider with a sign-fixup state, and a flush path for squashed ops.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MFHI = 3'd3;
  localparam logic [2:0] OP_MFLO = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5;
  localparam logic [2:0] OP_MTLO = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
  state_t state, state_nxt;

  logic accept, acc_mul, acc_div;
  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready & ~flush & (op != OP_NONE);
  assign acc_mul   = accept & (op == OP_MUL);
  assign acc_div   = accept & (op == OP_DIV);

  // Multiplier: the product is formed in the first stage, later stages only delay it.
  logic [2*WIDTH-1:0]                  ext_a, ext_b;
  logic [MUL_STAGES:1]                 vld_q;
  logic [MUL_STAGES:0]                 vld_pipe;
  logic [MUL_STAGES:1][2*WIDTH-1:0]    prod_pipe;

  assign ext_a    = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
  assign ext_b    = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
  assign vld_pipe = {vld_q, acc_mul};

  always_ff @(posedge clock) begin
    if (!reset_n || flush) vld_q <= '0;
    else                   vld_q <= vld_pipe[MUL_STAGES-1:0];
  end

  always_ff @(posedge clock) begin
    if (acc_mul) prod_pipe[1] <= ext_a * ext_b;
    for (int k = 2; k <= MUL_STAGES; k++) prod_pipe[k] <= prod_pipe[k-1];
  end

  // Divider: magnitudes in, signs applied once in FIX.
  logic [WIDTH-1:0] div_rem, div_q, div_b, mag_a, mag_b, rem_nxt, q_nxt;
  logic [WIDTH:0]   rem_sh, diff;
  logic             q_neg, r_neg, div_z, take;
  logic [CW-1:0]    cnt;

  assign mag_a   = (is_signed & a[WIDTH-1]) ? -a : a;
  assign mag_b   = (is_signed & b[WIDTH-1]) ? -b : b;
  assign rem_sh  = {div_rem, div_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, div_b};
  assign take    = ~diff[WIDTH];
  assign rem_nxt = take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign q_nxt   = {div_q[WIDTH-2:0], take};

  always_ff @(posedge clock) begin
    if (acc_div) begin
      div_rem <= '0;
      // On divide-by-zero the quotient register carries raw a for the HI write.
      div_q   <= (b == '0) ? a : mag_a;
      div_b   <= mag_b;
      div_z   <= (b == '0);
      q_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg   <= is_signed & a[WIDTH-1];
      cnt     <= '0;
    end else if (state == S_DIV) begin
      div_rem <= rem_nxt;
      div_q   <= q_nxt;
      cnt     <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (acc_mul)      state_nxt = S_MUL;
        else if (acc_div) state_nxt = (b == '0) ? S_FIX : S_DIV;
      end
      S_MUL:   if (vld_pipe[MUL_STAGES]) state_nxt = S_IDLE;
      S_DIV:   if (cnt == CW'(WIDTH-1))  state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      hi        <= '0;
      lo        <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (accept) begin
        case (op)
          OP_MTHI: hi <= a;
          OP_MTLO: lo <= a;
          OP_MFHI: begin res_valid <= 1'b1; res_data <= hi; end
          OP_MFLO: begin res_valid <= 1'b1; res_data <= lo; end
          default: ;
        endcase
      end
      if (!flush && vld_pipe[MUL_STAGES]) begin
        {hi, lo} <= prod_pipe[MUL_STAGES];
        done     <= 1'b1;
      end
      if (!flush && state == S_FIX) begin
        lo   <= div_z ? '1    : (q_neg ? -div_q   : div_q);
        hi   <= div_z ? div_q : (r_neg ? -div_rem : div_rem);
        done <= 1'b1;
      end
    end
  end

endmodule
